// File: rtl/misc_pipe_pkg.sv
// Shared types for the misc (jump/upper-immediate) execution pipe.
// Holds the op and exception-cause encodings plus a pointer-width helper for the result queue.
package misc_pipe_pkg;

  typedef enum logic [2:0] {
    INSTR_JALR  = 3'd0,
    INSTR_JAL   = 3'd1,
    INSTR_LUI   = 3'd2,
    INSTR_AUIPC = 3'd3,
    INSTR_INVAL = 3'd4
  } op_t;

  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGNED = 4'd0,
    EXC_ILLEGAL_INSTR    = 4'd2
  } exc_cause_t;

  localparam int REG_IDX_W = 5;

  // A one-entry queue still needs a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/misc_fifo.sv
// In-order result queue for misc_pipe: registered storage, wrapping pointers,
// and flush that clears occupancy and pointers at the next edge.
module misc_fifo
  import misc_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy next state; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; a push in a flush cycle is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/misc_pipe.sv
// Misc execution pipe: computes JAL/JALR/LUI/AUIPC results combinationally and
// queues them in order behind a decoupled valid/ready result interface.
module misc_pipe
  import misc_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int HAS_C = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  op_t                  in_op,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_rs1_val,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rvc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [XLEN-1:0]      out_rd_val,
  output logic                 out_br_valid,
  output logic [XLEN-1:0]      out_br_target,
  output logic                 out_exc_valid,
  output exc_cause_t           out_exc_cause,
  output logic [XLEN-1:0]      out_exc_tval
);

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      rd_val;
    logic                 br_valid;
    logic [XLEN-1:0]      br_target;
    logic                 exc_valid;
    exc_cause_t           exc_cause;
    logic [XLEN-1:0]      exc_tval;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  entry_t             res;
  entry_t             head;
  logic [XLEN-1:0]    link;
  logic [XLEN-1:0]    jalr_tgt;
  logic [XLEN-1:0]    jal_tgt;
  logic [ENTRY_W-1:0] rdata;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic               init_q;

  // Without C, a jump to a half-word boundary traps instead of redirecting.
  function automatic entry_t jump_result(input logic [XLEN-1:0] tgt,
                                         input logic [XLEN-1:0] lnk,
                                         input logic [REG_IDX_W-1:0] rd);
    entry_t r;
    r = '0;
    if ((HAS_C == 0) && tgt[1]) begin
      r.exc_valid = 1'b1;
      r.exc_cause = EXC_INSTR_MISALIGNED;
      r.exc_tval  = tgt;
    end else begin
      r.rd        = rd;
      r.rd_val    = lnk;
      r.br_valid  = 1'b1;
      r.br_target = tgt;
    end
    return r;
  endfunction

  // Result computation for the op presented this cycle.
  always_comb begin
    res      = '0;
    link     = in_pc + (((HAS_C != 0) && in_rvc) ? XLEN'(2) : XLEN'(4));
    jalr_tgt = (in_rs1_val + in_imm) & ~XLEN'(1);
    jal_tgt  = in_pc + in_imm;
    case (in_op)
      INSTR_JALR: res = jump_result(jalr_tgt, link, in_rd);
      INSTR_JAL:  res = jump_result(jal_tgt, link, in_rd);
      INSTR_LUI: begin
        res.rd     = in_rd;
        res.rd_val = in_imm;
      end
      INSTR_AUIPC: begin
        res.rd     = in_rd;
        res.rd_val = in_pc + in_imm;
      end
      default: begin
        res.exc_valid = 1'b1;
        res.exc_cause = EXC_ILLEGAL_INSTR;
        res.exc_tval  = in_pc;
      end
    endcase
  end

  // Holds off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  assign out_valid = (count != CNT_W'(0));
  assign pop       = out_valid && out_ready;
  assign in_ready  = init_q && ((count != CNT_W'(DEPTH)) || pop);
  assign push      = in_valid && in_ready;

  misc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (res),
    .rdata_o (rdata),
    .count_o (count)
  );

  assign head          = out_valid ? entry_t'(rdata) : '0;
  assign out_rd        = head.rd;
  assign out_rd_val    = head.rd_val;
  assign out_br_valid  = head.br_valid;
  assign out_br_target = head.br_target;
  assign out_exc_valid = head.exc_valid;
  assign out_exc_cause = head.exc_cause;
  assign out_exc_tval  = head.exc_tval;

endmodule

// File: tb/tb_misc_pipe.sv
// Self-checking bench for misc_pipe: a HAS_C=0 and a HAS_C=1 instance share stimulus,
// each with its own expected-result queue checked against the head every cycle.
module tb_misc_pipe;
  import misc_pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } exp_t;

  typedef struct {
    op_t         op;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rvc;
    exp_t        e0;
    exp_t        e1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, in_rvc;
  op_t         in_op;
  logic [31:0] in_pc, in_rs1_val, in_imm;
  logic [4:0]  in_rd;

  logic        in_ready0, out_valid0, br_valid0, exc_valid0;
  logic [4:0]  rd0;
  logic [31:0] rd_val0, br_target0, tval0;
  exc_cause_t  cause0;
  logic        in_ready1, out_valid1, br_valid1, exc_valid1;
  logic [4:0]  rd1;
  logic [31:0] rd_val1, br_target1, tval1;
  exc_cause_t  cause1;

  misc_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .HAS_C(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_imm(in_imm), .in_rd(in_rd),
    .in_rvc(in_rvc), .out_valid(out_valid0), .out_ready(out_ready), .out_rd(rd0),
    .out_rd_val(rd_val0), .out_br_valid(br_valid0), .out_br_target(br_target0),
    .out_exc_valid(exc_valid0), .out_exc_cause(cause0), .out_exc_tval(tval0)
  );

  misc_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .HAS_C(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_imm(in_imm), .in_rd(in_rd),
    .in_rvc(in_rvc), .out_valid(out_valid1), .out_ready(out_ready), .out_rd(rd1),
    .out_rd_val(rd_val1), .out_br_valid(br_valid1), .out_br_target(br_target1),
    .out_exc_valid(exc_valid1), .out_exc_cause(cause1), .out_exc_tval(tval1)
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur0, cur1;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] rv, input logic bv,
                              input logic [31:0] bt, input logic ev, input logic [3:0] c,
                              input logic [31:0] tv);
    exp_t e;
    e = '{rd: rd, rd_val: rv, br_valid: bv, br_target: bt, exc_valid: ev, cause: c, tval: tv};
    return e;
  endfunction

  function automatic exp_t act0();
    return {rd0, rd_val0, br_valid0, br_target0, exc_valid0, cause0, tval0};
  endfunction

  function automatic exp_t act1();
    return {rd1, rd_val1, br_valid1, br_target1, exc_valid1, cause1, tval1};
  endfunction

  task automatic drive(input op_t op, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [4:0] rd, input logic rvc,
                       input exp_t e0, input exp_t e1);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_rs1_val = rs1; in_imm = imm;
    in_rd = rd; in_rvc = rvc; cur0 = e0; cur1 = e1;
  endtask

  task automatic drive_lui(input logic [31:0] imm);
    drive(INSTR_LUI, 32'h0, 32'h0, imm, 5'd3, 1'b0, mk(5'd3, imm, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0),
          mk(5'd3, imm, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0));
  endtask

  // One clock: check both DUTs at the negedge, update the queues, return at posedge+1.
  task automatic step();
    logic vld0, vld1, rdy0, rdy1;
    @(negedge clk);
    vld0 = (q0.size() != 0);
    vld1 = (q1.size() != 0);
    rdy0 = (q0.size() < DEPTH) || out_ready;
    rdy1 = (q1.size() < DEPTH) || out_ready;
    chk("out_valid", out_valid0, vld0);
    chk("out_valid_c", out_valid1, vld1);
    chk("in_ready", in_ready0, rdy0);
    chk("in_ready_c", in_ready1, rdy1);
    if (vld0) chk("head", act0(), q0[0]);
    if (vld1) chk("head_c", act1(), q1[0]);
    if (vld0 && out_ready) void'(q0.pop_front());
    if (vld1 && out_ready) void'(q1.pop_front());
    if (in_valid && rdy0) q0.push_back(cur0);
    if (in_valid && rdy1) q1.push_back(cur1);
    if (flush) begin
      q0.delete();
      q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_out_valid"}, out_valid0, 1'b0);
    chk({nm, "_out_valid_c"}, out_valid1, 1'b0);
    chk({nm, "_in_ready"}, in_ready0, 1'b0);
    chk({nm, "_in_ready_c"}, in_ready1, 1'b0);
    chk({nm, "_payload"}, act0(), 107'd0);
    chk({nm, "_payload_c"}, act1(), 107'd0);
  endtask

  // Asynchronous reset pulse, held across one edge, released between edges.
  task automatic do_reset(input string nm);
    rst = 1'b0;
    #1;
    chk_reset_outs(nm);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    chk_reset_outs({nm, "_held"});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rvc = 1'b0;
    in_op = INSTR_LUI; in_pc = '0; in_rs1_val = '0; in_imm = '0; in_rd = '0;
    cur0 = '0; cur1 = '0;

    vecs[0] = '{INSTR_JALR, 32'h100, 32'h2001, 32'h4, 5'd1, 1'b0,
                mk(5'd1, 32'h104, 1'b1, 32'h2004, 1'b0, 4'd0, 32'h0),
                mk(5'd1, 32'h104, 1'b1, 32'h2004, 1'b0, 4'd0, 32'h0)};
    vecs[1] = '{INSTR_JAL, 32'h200, 32'h0, 32'h10, 5'd2, 1'b1,
                mk(5'd2, 32'h204, 1'b1, 32'h210, 1'b0, 4'd0, 32'h0),
                mk(5'd2, 32'h202, 1'b1, 32'h210, 1'b0, 4'd0, 32'h0)};
    vecs[2] = '{INSTR_JAL, 32'h200, 32'h0, 32'h12, 5'd3, 1'b0,
                mk(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd0, 32'h212),
                mk(5'd3, 32'h204, 1'b1, 32'h212, 1'b0, 4'd0, 32'h0)};
    vecs[3] = '{INSTR_LUI, 32'h300, 32'h0, 32'h12345000, 5'd4, 1'b0,
                mk(5'd4, 32'h12345000, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0),
                mk(5'd4, 32'h12345000, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0)};
    vecs[4] = '{INSTR_AUIPC, 32'h1000, 32'h0, 32'hFFFFF000, 5'd6, 1'b0,
                mk(5'd6, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0),
                mk(5'd6, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0)};
    vecs[5] = '{INSTR_INVAL, 32'h40, 32'h0, 32'h0, 5'd5, 1'b0,
                mk(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd2, 32'h40),
                mk(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd2, 32'h40)};
    vecs[6] = '{INSTR_JALR, 32'hFFFFFFFC, 32'h3, 32'h0, 5'd7, 1'b1,
                mk(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd0, 32'h2),
                mk(5'd7, 32'hFFFFFFFE, 1'b1, 32'h2, 1'b0, 4'd0, 32'h0)};
    vecs[7] = '{op_t'(3'd7), 32'h80, 32'h0, 32'h0, 5'd9, 1'b0,
                mk(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd2, 32'h80),
                mk(5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd2, 32'h80)};

    do_reset("reset");

    // Table vectors back to back at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].pc, vecs[i].rs1, vecs[i].imm, vecs[i].rd, vecs[i].rvc,
            vecs[i].e0, vecs[i].e1);
      step();
    end
    idle_steps(3);

    // Backpressure: third LUI held until out_ready rises, then in-order drain.
    out_ready = 1'b0;
    drive_lui(32'd1); step();
    drive_lui(32'd2); step();
    drive_lui(32'd3); step();
    step();
    out_ready = 1'b1;
    step();
    idle_steps(4);

    // Full queue with simultaneous push/pop every cycle.
    out_ready = 1'b0;
    drive_lui(32'h50); step();
    drive_lui(32'h51); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_lui(32'h100 + 32'(i));
      step();
    end
    idle_steps(3);

    // Flush with two queued and a concurrent accepted input.
    out_ready = 1'b0;
    drive_lui(32'h60); step();
    drive_lui(32'h61); step();
    out_ready = 1'b1; flush = 1'b1;
    drive_lui(32'hDEAD); step();
    flush = 1'b0;
    idle_steps(3);

    // Flush with one queued: input still accepted (no stall) but dropped.
    out_ready = 1'b0;
    drive_lui(32'h70); step();
    flush = 1'b1;
    drive_lui(32'hBEEF); step();
    flush = 1'b0;
    out_ready = 1'b1;
    idle_steps(3);

    // Asynchronous reset with entries queued.
    out_ready = 1'b0;
    drive_lui(32'h80); step();
    drive(vecs[5].op, vecs[5].pc, vecs[5].rs1, vecs[5].imm, vecs[5].rd, vecs[5].rvc,
          vecs[5].e0, vecs[5].e1);
    step();
    in_valid = 1'b0;
    do_reset("midreset");
    out_ready = 1'b1;
    drive_lui(32'h90); step();
    idle_steps(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
